// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller and its environment.
// Producer side: in_valid/in_data/stage_done. Controller side: in_ready,
// stage_valid, stage_data (stage k at slice k), stage_fire.
interface pipe_ctrl_if #(
    parameter int STAGES = 4,
    parameter int DATA_W = 64
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic [STAGES-1:0]        stage_done;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic [STAGES-1:0]        stage_fire;

    modport master (
        output in_valid,
        output in_data,
        output stage_done,
        input  in_ready,
        input  stage_valid,
        input  stage_data,
        input  stage_fire
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  stage_done,
        output in_ready,
        output stage_valid,
        output stage_data,
        output stage_fire
    );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller with backpressure, partial flush and
// saturating performance counters.
// Ports: clk, reset (sync, active-high); bus (pipe_ctrl_if.slave) carries
// the entry handshake and per-stage status; flush/flush_stage kill stages
// 0..flush_stage; cnt_clr zeroes retire_cnt, stall_cnt and bubble_cnt.
module pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    pipe_ctrl_if.slave                bus,
    input  logic                      flush,
    input  logic [$clog2(STAGES)-1:0] flush_stage,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          retire_cnt,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];

    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic [STAGES-1:0] live;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] fire;
    logic [STAGES-1:0] inc;
    int                fs_lim;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Handshake chain, evaluated from the oldest stage back to fetch.
    // While reset is held every stage looks empty, so in_ready reads 1
    // and nothing fires.
    always_comb begin
        live        = valid_q & ~{STAGES{reset}};
        rdy         = '0;
        rdy[STAGES] = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !live[k] || (bus.stage_done[k] && rdy[k+1]);
        end
    end

    // Out-of-range flush_stage folds onto the oldest stage.
    always_comb begin
        fs_lim = int'(flush_stage);
        if (fs_lim > STAGES - 1) begin
            fs_lim = STAGES - 1;
        end
        kill = '0;
        for (int k = 0; k < STAGES; k++) begin
            kill[k] = flush && (k <= fs_lim);
        end
    end

    always_comb begin
        fire = '0;
        for (int k = 0; k < STAGES; k++) begin
            fire[k] = live[k] && bus.stage_done[k]
                   && rdy[k+1] && !kill[k];
        end
        inc    = '0;
        inc[0] = bus.in_valid && rdy[0] && !kill[0];
        for (int k = 1; k < STAGES; k++) begin
            inc[k] = fire[k-1];
        end
    end

    // A ready stage takes whatever arrives (possibly nothing); a stalled
    // stage holds. Kill only clears the valid bit, payload stays put.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end
        if (rdy[0]) begin
            valid_d[0] = inc[0];
            if (inc[0]) begin
                data_d[0] = bus.in_data;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                valid_d[k] = inc[k];
                if (inc[k]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
        valid_d = valid_d & ~kill;
    end

    always_comb begin
        if (cnt_clr) begin
            retire_d = '0;
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            retire_d = sat_inc(retire_q, fire[STAGES-1]);
            stall_d  = sat_inc(stall_q, bus.in_valid && !rdy[0]);
            bubble_d = sat_inc(bubble_q, !valid_q[STAGES-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        bus.stage_data = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.stage_data[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign bus.in_ready    = rdy[0];
    assign bus.stage_fire  = fire;
    assign bus.stage_valid = valid_q;

    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STAGES=4, DATA_W=8, CNT_W=8).
// Vector table, directed corner sequences and random traffic vs a model.
module tb_pipe_ctrl;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int CMAX = 255;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [1:0]    flush_stage;
    logic          cnt_clr;
    logic [CW-1:0] retire_cnt;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    pipe_ctrl_if #(.STAGES(S), .DATA_W(DW)) bus ();

    pipe_ctrl #(.STAGES(S), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .flush       (flush),
        .flush_stage (flush_stage),
        .cnt_clr     (cnt_clr),
        .retire_cnt  (retire_cnt),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy and payload per slot, counters as ints.
    bit          mv [S];
    logic [7:0]  md [S];
    int          mr, ms, mb;
    bit          e_rdy;
    bit [S-1:0]  e_fire;
    bit [S-1:0]  e_kill;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic [3:0] done;
        logic       rdy;
        logic [3:0] fire;
        logic [3:0] vld;
        logic [7:0] d3;
    } vec_t;

    vec_t       tbl [13];
    logic [3:0] vl  [13] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF,
                             4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // An entry may leave its slot when its work is done and the slot
    // ahead of it is free or itself emptying this cycle.
    task automatic model_comb();
        int fs;
        bit open [S+1];
        bit occ;
        fs = int'(flush_stage);
        if (fs > S - 1) fs = S - 1;
        open[S] = 1'b1;
        for (int k = S - 1; k >= 0; k--) begin
            occ = !reset && mv[k];
            open[k] = !occ || (bus.stage_done[k] && open[k+1]);
        end
        for (int k = 0; k < S; k++) begin
            e_kill[k] = flush && (k <= fs);
            e_fire[k] = !reset && mv[k] && bus.stage_done[k]
                     && open[k+1] && !e_kill[k];
        end
        e_rdy = open[0];
    endtask

    task automatic model_update();
        bit old3;
        old3 = mv[S-1];
        if (reset) begin
            for (int k = 0; k < S; k++) begin
                mv[k] = 1'b0;
                md[k] = 8'h00;
            end
            mr = 0; ms = 0; mb = 0;
        end else begin
            for (int k = S - 1; k >= 0; k--) begin
                if (e_fire[k]) begin
                    mv[k] = 1'b0;
                    if (k < S - 1) begin
                        mv[k+1] = 1'b1;
                        md[k+1] = md[k];
                    end
                end
            end
            if (bus.in_valid && e_rdy && !e_kill[0]) begin
                mv[0] = 1'b1;
                md[0] = bus.in_data;
            end
            for (int k = 0; k < S; k++) begin
                if (e_kill[k]) mv[k] = 1'b0;
            end
            if (cnt_clr) begin
                mr = 0; ms = 0; mb = 0;
            end else begin
                mr = sat(mr + int'(e_fire[S-1]));
                ms = sat(ms + int'(bus.in_valid && !e_rdy));
                mb = sat(mb + int'(!old3));
            end
        end
    endtask

    task automatic sample();
        logic [3:0]  ev;
        logic [31:0] ed;
        @(negedge clk);
        model_comb();
        for (int k = 0; k < S; k++) begin
            ev[k]         = mv[k];
            ed[k*8 +: 8]  = md[k];
        end
        chk("in_ready", bus.in_ready, e_rdy);
        chk("stage_fire", bus.stage_fire, e_fire);
        chk("stage_valid", bus.stage_valid, ev);
        chk("stage_data", bus.stage_data, ed);
        chk("retire_cnt", retire_cnt, mr[7:0]);
        chk("stall_cnt", stall_cnt, ms[7:0]);
        chk("bubble_cnt", bubble_cnt, mb[7:0]);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.stage_done = 4'hF;
        flush          = 1'b0;
        flush_stage    = 2'd0;
        cnt_clr        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        bus.stage_done = 4'hF;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < S; i++) begin
            bus.in_data = base + 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] rc;
        logic [7:0] first;
        int         nret;

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end
        mr = 0; ms = 0; mb = 0;
        reset = 1'b0;

        // Reset state
        sample();
        chk("rst_valid", bus.stage_valid, 4'h0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_retire", retire_cnt, 8'h00);
        advance();
        do_reset();

        // Streaming 0x01..0x08, all stages done every cycle
        for (int c = 0; c < 13; c++) begin
            tbl[c].iv   = (c < 8);
            tbl[c].id   = 8'(c + 1);
            tbl[c].done = 4'hF;
            tbl[c].rdy  = 1'b1;
            tbl[c].vld  = vl[c];
            tbl[c].fire = vl[c];
            tbl[c].d3   = 8'(c - 3);
        end
        for (int c = 0; c < 13; c++) begin
            bus.in_valid   = tbl[c].iv;
            bus.in_data    = tbl[c].id;
            bus.stage_done = tbl[c].done;
            sample();
            chk("tbl_ready", bus.in_ready, tbl[c].rdy);
            chk("tbl_fire", bus.stage_fire, tbl[c].fire);
            chk("tbl_valid", bus.stage_valid, tbl[c].vld);
            if (tbl[c].vld[3])
                chk("tbl_d3", bus.stage_data[31:24], tbl[c].d3);
            advance();
        end
        sample();
        chk("stream_retire", retire_cnt, 8'd8);
        chk("stream_stall", stall_cnt, 8'd0);
        advance();

        // Stage 2 stalls for three cycles with a full pipe
        do_reset();
        fill(8'h10);
        bus.stage_done = 4'b1011;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h14;
        b0 = bubble_cnt;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("stall_ready", bus.in_ready, 1'b0);
            advance();
        end
        bus.in_valid = 1'b0;
        sample();
        chk("stall_cnt3", stall_cnt, 8'd3);
        chk("stall_bubble", bubble_cnt, b0 + 8'd2);
        chk("stall_s3", bus.stage_valid[3], 1'b0);
        advance();
        bus.stage_done = 4'hF;

        // Partial flush of stages 0..1 with a full pipe
        do_reset();
        fill(8'hA0);
        flush       = 1'b1;
        flush_stage = 2'd1;
        sample();
        chk("pflush_fire", bus.stage_fire, 4'b1100);
        advance();
        flush = 1'b0;
        nret  = 0;
        first = 8'h00;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (i == 0) begin
                chk("pflush_valid", bus.stage_valid, 4'b1000);
                chk("pflush_d3", bus.stage_data[31:24], 8'hA1);
            end
            if (bus.stage_fire[3]) begin
                if (nret == 0) first = bus.stage_data[31:24];
                nret++;
            end
            advance();
        end
        chk("pflush_nret", nret, 1);
        chk("pflush_first", first, 8'hA1);

        // Full flush while the oldest stage is done
        do_reset();
        fill(8'h60);
        flush       = 1'b1;
        flush_stage = 2'd3;
        sample();
        chk("fflush_fire", bus.stage_fire, 4'b0000);
        rc = retire_cnt;
        advance();
        flush = 1'b0;
        sample();
        chk("fflush_valid", bus.stage_valid, 4'b0000);
        chk("fflush_retire", retire_cnt, rc);
        advance();

        // Saturating stall counter and counter clear
        do_reset();
        fill(8'h40);
        bus.stage_done = 4'b0111;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 300; i++) step();
        sample();
        chk("sat_stall", stall_cnt, 8'd255);
        advance();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        sample();
        chk("clr_stall", stall_cnt, 8'd0);
        chk("clr_retire", retire_cnt, 8'd0);
        chk("clr_bubble", bubble_cnt, 8'd0);
        advance();
        bus.in_valid   = 1'b0;
        bus.stage_done = 4'hF;

        // Reset with a full pipe, then a single entry
        do_reset();
        fill(8'h30);
        bus.stage_done = 4'b0111;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        sample();
        chk("rstmid_ready", bus.in_ready, 1'b1);
        chk("rstmid_fire", bus.stage_fire, 4'b0000);
        advance();
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.stage_done = 4'hF;
        sample();
        chk("rstmid_valid", bus.stage_valid, 4'b0000);
        chk("rstmid_cnt", {retire_cnt, stall_cnt, bubble_cnt}, 24'h0);
        advance();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        sample();
        chk("inj_accept", bus.in_ready, 1'b1);
        advance();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sample();
            if (i < 4) begin
                chk("inj_early", bus.stage_fire[3], 1'b0);
            end else begin
                chk("inj_retire", bus.stage_fire[3], 1'b1);
                chk("inj_data", bus.stage_data[31:24], 8'h55);
            end
            advance();
        end

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.in_valid   = ($urandom_range(0, 9) < 7);
            bus.in_data    = 8'($urandom);
            bus.stage_done = 4'($urandom | $urandom);
            flush          = ($urandom_range(0, 19) == 0);
            flush_stage    = 2'($urandom);
            cnt_clr        = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
